// File: rtl/des_perm_pipe.sv
// Pipelined DES IP / IP^-1 / bypass permutation engine with credit-based output FIFO.
// Optional self-check of the final stage against the original input: define DES_PERM_CHECK_EN.
module des_perm_pipe #(
    parameter int unsigned STAGES    = 2,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [1:0]       IN_MODE,
    input  logic [63:0]      IN_DATA,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [1:0]       OUT_MODE,
    output logic [63:0]      OUT_DATA,
    output logic [CNT_W-1:0] BLK_CNT,
    output logic             MODE_ERR,
    output logic             CHK_ERR
);

    localparam int unsigned PTR_W = $clog2(OUT_DEPTH);
    localparam int unsigned FCNT_W = $clog2(OUT_DEPTH + 1);
    localparam int unsigned OCC_W = $clog2(OUT_DEPTH + STAGES + 1);
    localparam int unsigned LAST = STAGES - 1;

    // Source DES bit number (1 = MSB) for IP output bit i (1..64).
    function automatic int unsigned ip_src(input int unsigned i);
        int unsigned row, col, base;
        row  = (i - 1) / 8;
        col  = (i - 1) % 8;
        base = (row < 4) ? 58 + 2 * row : 57 + 2 * (row - 4);
        return base - 8 * col;
    endfunction

    function automatic logic [63:0] perm(input logic [63:0] d, input logic inverse);
        logic [63:0] r;
        logic [5:0]  o, s;
        r = '0;
        for (int unsigned i = 1; i <= 64; i++) begin
            o = 6'(64 - i);
            s = 6'(64 - ip_src(i));
            if (inverse) r[s] = d[o];
            else         r[o] = d[s];
        end
        return r;
    endfunction

    function automatic logic [63:0] apply(input logic [63:0] d, input logic [1:0] mode, input logic undo);
        logic [63:0] r;
        unique case (mode)
            2'b00:   r = perm(d, undo);
            2'b01:   r = perm(d, !undo);
            default: r = d;
        endcase
        return r;
    endfunction

    logic              accept;
    logic [63:0]       perm_d;
    logic              stg_vld  [STAGES];
    logic [63:0]       stg_data [STAGES];
    logic [1:0]        stg_mode [STAGES];
    logic [65:0]       mem      [OUT_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] fifo_cnt;
    logic [OCC_W-1:0]  occ;
    logic              ready_q;
    logic              wr_en, rd_en;
    logic [65:0]       head;

    assign perm_d = apply(IN_DATA, IN_MODE, 1'b0);
    assign accept = IN_VALID && IN_READY;
    assign wr_en  = stg_vld[LAST];
    assign rd_en  = OUT_VALID && OUT_READY;

    // Credits count everything already committed downstream, so the FIFO can never overflow.
    always_comb begin
        occ = OCC_W'(fifo_cnt);
        for (int s = 0; s < STAGES; s++) occ = occ + OCC_W'(stg_vld[s]);
    end

    assign IN_READY = ready_q && (occ < OCC_W'(OUT_DEPTH));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ready_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) begin
                stg_vld[s]  <= 1'b0;
                stg_data[s] <= '0;
                stg_mode[s] <= '0;
            end
        end else begin
            ready_q     <= 1'b1;
            stg_vld[0]  <= accept;
            stg_data[0] <= perm_d;
            stg_mode[0] <= IN_MODE;
            for (int s = 1; s < STAGES; s++) begin
                stg_vld[s]  <= stg_vld[s-1];
                stg_data[s] <= stg_data[s-1];
                stg_mode[s] <= stg_mode[s-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= {stg_mode[LAST], stg_data[LAST]};
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            BLK_CNT  <= '0;
            MODE_ERR <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
            if (wr_en && !rd_en)      fifo_cnt <= fifo_cnt + FCNT_W'(1);
            else if (!wr_en && rd_en) fifo_cnt <= fifo_cnt - FCNT_W'(1);
            if (rd_en && (BLK_CNT != '1)) BLK_CNT <= BLK_CNT + CNT_W'(1);
            if (accept && (IN_MODE == 2'b11)) MODE_ERR <= 1'b1;
        end
    end

    assign OUT_VALID = (fifo_cnt != '0);
    assign head      = mem[rd_ptr];
    assign OUT_DATA  = OUT_VALID ? head[63:0] : '0;
    assign OUT_MODE  = OUT_VALID ? head[65:64] : '0;

`ifdef DES_PERM_CHECK_EN
    logic [63:0] stg_orig [STAGES];
    logic [63:0] chk_data;
    logic        chk_err_q;

    assign chk_data = apply(stg_data[LAST], stg_mode[LAST], 1'b1);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            chk_err_q <= 1'b0;
            for (int s = 0; s < STAGES; s++) stg_orig[s] <= '0;
        end else begin
            stg_orig[0] <= IN_DATA;
            for (int s = 1; s < STAGES; s++) stg_orig[s] <= stg_orig[s-1];
            if (stg_vld[LAST] && (chk_data != stg_orig[LAST])) chk_err_q <= 1'b1;
        end
    end

    assign CHK_ERR = chk_err_q;
`else
    assign CHK_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_des_perm_pipe.sv
// Directed bench for des_perm_pipe with a scoreboard queue and immediate-assertion checks.
module tb_des_perm_pipe;

    localparam int unsigned STAGES = 2;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CW     = 4;

    logic          clk, rst_n;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [1:0]    in_mode, out_mode;
    logic [63:0]   in_data, out_data;
    logic [CW-1:0] blk_cnt;
    logic          mode_err, chk_err;

    des_perm_pipe #(.STAGES(STAGES), .OUT_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(in_valid), .IN_READY(in_ready),
        .IN_MODE(in_mode), .IN_DATA(in_data), .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OUT_MODE(out_mode), .OUT_DATA(out_data), .BLK_CNT(blk_cnt), .MODE_ERR(mode_err),
        .CHK_ERR(chk_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int ip_t [64] = '{58, 50, 42, 34, 26, 18, 10, 2,
                      60, 52, 44, 36, 28, 20, 12, 4,
                      62, 54, 46, 38, 30, 22, 14, 6,
                      64, 56, 48, 40, 32, 24, 16, 8,
                      57, 49, 41, 33, 25, 17,  9, 1,
                      59, 51, 43, 35, 27, 19, 11, 3,
                      61, 53, 45, 37, 29, 21, 13, 5,
                      63, 55, 47, 39, 31, 23, 15, 7};

    logic [65:0] exp_q [$];
    int n_pass = 0;
    int n_chk = 0;
    int mcnt = 0;
    int n_deliv = 0;

    function automatic logic [63:0] model(input logic [63:0] d, input logic [1:0] m);
        logic [63:0] r;
        logic [5:0]  a, b;
        r = d;
        if (m == 2'b00 || m == 2'b01) begin
            r = '0;
            for (int i = 0; i < 64; i++) begin
                a = 6'(63 - i);
                b = 6'(64 - ip_t[i]);
                if (m == 2'b00) r[a] = d[b];
                else            r[b] = d[a];
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h required %h", tag, obs, exp);
    endtask

    // Called at a falling edge; records handshakes for the coming rising edge.
    task automatic tick();
        logic [65:0] e;
        #1;
        if (in_valid && in_ready) exp_q.push_back({in_mode, model(in_data, in_mode)});
        if (out_valid && out_ready) begin
            n_deliv++;
            if (mcnt != 15) mcnt++;
            n_chk++;
            assert (exp_q.size() > 0) n_pass++;
            else $error("FAIL spurious_out: observed %h with empty scoreboard, required none", out_data);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_data", out_data, e[63:0]);
                chk("sb_mode", 64'(out_mode), 64'(e[65:64]));
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] d, input logic [1:0] m);
        int b;
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        b = 0;
        while (!in_ready && b < 50) begin
            tick();
            b++;
        end
        chk("send_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int b;
        out_ready = 1'b1;
        b = 0;
        while ((exp_q.size() != 0 || out_valid) && b < 200) begin
            tick();
            b++;
        end
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        chk("blk_cnt", 64'(blk_cnt), 64'(mcnt));
    endtask

    task automatic one_block(input string tag, input logic [63:0] d, input logic [1:0] m,
                             input logic [63:0] want);
        int lat;
        out_ready = 1'b1;
        send(d, m);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(STAGES));
        chk({tag, "_data"}, out_data, want);
        chk({tag, "_mode"}, 64'(out_mode), 64'(m));
        drain();
    endtask

    logic [63:0] blk [20];
    int idx, d0;
    logic acc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mode = '0; in_data = '0; out_ready = 1'b0;
        for (int i = 0; i < 20; i++) blk[i] = {$urandom, $urandom};

        #23;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_out_data", out_data, 64'(0));
        chk("rst_blk_cnt", 64'(blk_cnt), 64'(0));
        chk("rst_mode_err", 64'(mode_err), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 64'(in_ready), 64'(0));
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_edge", 64'(in_ready), 64'(1));

        // Known IP vector, its inverse, and a walking one.
        one_block("ip", 64'h0123456789ABCDEF, 2'b00, 64'hCC00CCFFF0AAF0AA);
        chk("blk_cnt_one", 64'(blk_cnt), 64'(1));
        one_block("ipinv", 64'hCC00CCFFF0AAF0AA, 2'b01, 64'h0123456789ABCDEF);
        one_block("walk58", 64'h40, 2'b00, 64'h8000000000000000);

        // Backpressure: only DEPTH blocks fit while the consumer stalls.
        d0 = n_deliv;
        out_ready = 1'b0;
        in_valid = 1'b1;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_data = blk[idx];
            in_mode = 2'(idx % 3);
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp_accepted", 64'(idx), 64'(DEPTH));
        chk("bp_in_ready", 64'(in_ready), 64'(0));
        chk("bp_out_valid", 64'(out_valid), 64'(1));
        chk("bp_hold_data", out_data, exp_q[0][63:0]);
        out_ready = 1'b1;
        for (int c = 0; c < 100 && idx < 10; c++) begin
            in_data = blk[idx];
            in_mode = 2'(idx % 3);
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        drain();
        chk("bp_delivered", 64'(n_deliv - d0), 64'(10));

        // Reserved mode passes through and latches MODE_ERR.
        one_block("mode11", 64'hDEADBEEF00000001, 2'b11, 64'hDEADBEEF00000001);
        chk("mode_err_set", 64'(mode_err), 64'(1));
        one_block("bypass", 64'h5A5A5A5A12345678, 2'b10, 64'h5A5A5A5A12345678);
        chk("mode_err_held", 64'(mode_err), 64'(1));

        // Counter saturation at 2^CW-1.
        out_ready = 1'b1;
        in_valid = 1'b1;
        idx = 0;
        for (int c = 0; c < 200 && idx < 20; c++) begin
            in_data = blk[idx];
            in_mode = 2'(idx % 4);
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        drain();
        chk("blk_cnt_sat", 64'(blk_cnt), 64'(15));

        // Reset with the FIFO and pipeline loaded discards everything.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = blk[c];
            in_mode = 2'b00;
            tick();
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
        chk("mid_rst_out_data", out_data, 64'(0));
        chk("mid_rst_out_mode", 64'(out_mode), 64'(0));
        chk("mid_rst_blk_cnt", 64'(blk_cnt), 64'(0));
        chk("mid_rst_mode_err", 64'(mode_err), 64'(0));
        exp_q.delete();
        mcnt = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        chk("post_rst_no_stale", 64'(out_valid), 64'(0));
        one_block("post_rst", 64'h0123456789ABCDEF, 2'b00, 64'hCC00CCFFF0AAF0AA);
        chk("post_rst_cnt", 64'(blk_cnt), 64'(1));
        chk("chk_err_off", 64'(chk_err), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
